// File: rtl/tracer_pkg.sv
// Shared types and widths for the retired-step trace buffer.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
package tracer_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned OVF_W      = 32;

  // One register writeback recorded against a step.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } reg_action_t;

  // Width needed to count 0..n register actions.
  function automatic int unsigned regcnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trace_step_buffer.sv
// Retired-step trace buffer: circular table of executed steps, popped in order once complete.
// Latency: non-memop step readable 1 cycle after i_e_valid; memop step 1 cycle after i_m_complete.
// Backpressure: head held until i_rd_ready; when full the oldest is overwritten (DROP_OLDEST=1) or o_stall and discard.
// Optional feature macro: TRACER_MEMDATA_EN keeps memop address/data/store storage and outputs.
module trace_step_buffer
  import tracer_pkg::*;
#(
  parameter int unsigned ABITS       = 6,
  parameter int unsigned REGACT_MAX  = 4,
  parameter bit          DROP_OLDEST = 1'b1
) (
  input  logic                               i_clk,
  input  logic                               i_nrst,
  input  logic                               i_e_valid,
  input  logic [63:0]                        i_e_pc,
  input  logic [31:0]                        i_e_instr,
  input  logic                               i_e_memop,
  input  logic                               i_e_memop_store,
  input  logic [63:0]                        i_e_memop_addr,
  input  logic                               i_reg_wena,
  input  logic [5:0]                         i_reg_waddr,
  input  logic [63:0]                        i_reg_wdata,
  input  logic                               i_m_complete,
  input  logic [63:0]                        i_m_data,
  output logic                               o_rd_valid,
  input  logic                               i_rd_ready,
  output logic [63:0]                        o_rd_exec_cnt,
  output logic [63:0]                        o_rd_pc,
  output logic [31:0]                        o_rd_instr,
  output logic [$clog2(REGACT_MAX+1)-1:0]    o_rd_regcnt,
  output logic [6*REGACT_MAX-1:0]            o_rd_regaddr,
  output logic [64*REGACT_MAX-1:0]           o_rd_regdata,
  output logic                               o_rd_memop,
  output logic                               o_rd_store,
  output logic [63:0]                        o_rd_memaddr,
  output logic [63:0]                        o_rd_memdata,
  output logic                               o_full,
  output logic                               o_stall,
  output logic [31:0]                        o_overflow_cnt
);

  localparam int unsigned DEPTH  = 2 ** ABITS;
  localparam int unsigned RCW    = regcnt_width(REGACT_MAX);
  localparam int unsigned SLOT_W = (REGACT_MAX > 1) ? $clog2(REGACT_MAX) : 1;
  localparam logic [ABITS:0]  TOTAL_FULL = (ABITS+1)'(DEPTH);
  localparam logic [RCW-1:0]  REGCNT_MAX = RCW'(REGACT_MAX);

  // One table entry; completed gates readout, memop marks entries waiting on the memory stage.
  typedef struct packed {
    logic [XLEN-1:0]                    exec_cnt;
    logic [XLEN-1:0]                    pc;
    logic [INSTR_W-1:0]                 instr;
    logic [RCW-1:0]                     regcnt;
    reg_action_t [REGACT_MAX-1:0]       regs;
    logic                               memop;
    logic                               completed;
`ifdef TRACER_MEMDATA_EN
    logic                               store;
    logic [XLEN-1:0]                    memaddr;
    logic [XLEN-1:0]                    memdata;
`endif
  } trace_step_t;

  trace_step_t          entries_q [DEPTH];

  logic [ABITS-1:0]     wcnt_q, wcnt_d;
  logic [ABITS-1:0]     rcnt_q, rcnt_d;
  logic [ABITS-1:0]     mcnt_q, mcnt_d;
  logic [ABITS:0]       total_q, total_d;
  logic [ABITS:0]       mpend_q, mpend_d;
  logic [XLEN-1:0]      exec_cnt_q, exec_cnt_d;
  logic [OVF_W-1:0]     ovf_q, ovf_d;

  trace_step_t          head;
  trace_step_t          new_entry;
  logic                 full;
  logic                 pop;
  logic                 lost;
  logic                 drop;
  logic                 accept;
  logic [ABITS-1:0]     young_idx;
  logic [SLOT_W-1:0]    reg_slot;
  logic                 reg_upd;
  logic                 head_pending;
  logic                 m_upd;
  logic                 m_retire;
  logic [ABITS:0]       mpend_left;
  logic [ABITS-1:0]     scan_idx;

  // Head view and the accept/drop/pop decision for this cycle.
  always_comb begin
    head       = entries_q[rcnt_q];
    full       = (total_q == TOTAL_FULL);
    o_rd_valid = (total_q != '0) && head.completed;
    pop        = o_rd_valid && i_rd_ready;
    // A step is lost only when the table stays full this cycle (no pop frees a slot).
    lost       = i_e_valid && full && !pop;
    drop       = lost && DROP_OLDEST;
    accept     = i_e_valid && !(lost && !DROP_OLDEST);
  end

  // Build the record for a newly executed step; a same-cycle writeback lands in slot 0.
  always_comb begin
    new_entry           = '0;
    new_entry.exec_cnt  = exec_cnt_q;
    new_entry.pc        = i_e_pc;
    new_entry.instr     = i_e_instr;
    new_entry.memop     = i_e_memop;
    new_entry.completed = !i_e_memop;
`ifdef TRACER_MEMDATA_EN
    new_entry.store     = i_e_memop_store;
    new_entry.memaddr   = i_e_memop_addr;
`endif
    if (i_reg_wena) begin
      new_entry.regs[0].addr = i_reg_waddr;
      new_entry.regs[0].data = i_reg_wdata;
      new_entry.regcnt       = RCW'(1);
    end
  end

  // Writeback without a new step attaches to the youngest entry while slots remain.
  always_comb begin
    young_idx = wcnt_q - 1'b1;
    reg_slot  = SLOT_W'(entries_q[young_idx].regcnt);
    reg_upd   = i_reg_wena && !i_e_valid && (total_q != '0) &&
                (entries_q[young_idx].regcnt < REGCNT_MAX);
  end

  // Track the oldest pending memop: completion or a dropped pending head retires it.
  always_comb begin
    head_pending = (mpend_q != '0) && (mcnt_q == rcnt_q) && head.memop && !head.completed;
    m_upd        = i_m_complete && (mpend_q != '0);
    m_retire     = m_upd || (drop && head_pending);
    mpend_left   = mpend_q - (ABITS+1)'(m_retire);
    // Nearest memop entry after mcnt; entries past the youngest come last in ring order,
    // so while older memops remain pending the first hit is always a live one.
    scan_idx = mcnt_q;
    for (int d = int'(DEPTH) - 1; d >= 1; d--) begin
      if (entries_q[mcnt_q + ABITS'(d)].memop) begin
        scan_idx = mcnt_q + ABITS'(d);
      end
    end
    mcnt_d = mcnt_q;
    if (m_retire && (mpend_left != '0)) begin
      mcnt_d = scan_idx;
    end else if (accept && i_e_memop && (mpend_left == '0)) begin
      mcnt_d = wcnt_q;
    end
    mpend_d = mpend_left + (ABITS+1)'(accept && i_e_memop);
  end

  // Pointer, occupancy and counter next-state.
  always_comb begin
    wcnt_d  = wcnt_q + ABITS'(accept);
    rcnt_d  = rcnt_q + ABITS'(pop || drop);
    total_d = total_q;
    if (accept && !pop && !drop) begin
      total_d = total_q + 1'b1;
    end else if (!accept && pop) begin
      total_d = total_q - 1'b1;
    end
    exec_cnt_d = exec_cnt_q + XLEN'(i_e_valid);
    ovf_d      = lost ? sat_inc(ovf_q) : ovf_q;
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      mcnt_q     <= '0;
      total_q    <= '0;
      mpend_q    <= '0;
      exec_cnt_q <= '0;
      ovf_q      <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      mcnt_q     <= mcnt_d;
      total_q    <= total_d;
      mpend_q    <= mpend_d;
      exec_cnt_q <= exec_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Table storage; a new step written over a dropped head overrides that head's completion.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      if (m_upd) begin
        entries_q[mcnt_q].completed <= 1'b1;
`ifdef TRACER_MEMDATA_EN
        entries_q[mcnt_q].memdata   <= i_m_data;
`endif
      end
      if (accept) begin
        entries_q[wcnt_q] <= new_entry;
      end else if (reg_upd) begin
        entries_q[young_idx].regs[reg_slot] <= '{addr: i_reg_waddr, data: i_reg_wdata};
        entries_q[young_idx].regcnt         <= entries_q[young_idx].regcnt + 1'b1;
      end
    end
  end

  // Readout fields straight from the head entry.
  always_comb begin
    o_rd_exec_cnt = head.exec_cnt;
    o_rd_pc       = head.pc;
    o_rd_instr    = head.instr;
    o_rd_regcnt   = head.regcnt;
    o_rd_memop    = head.memop;
    o_rd_regaddr  = '0;
    o_rd_regdata  = '0;
    for (int s = 0; s < int'(REGACT_MAX); s++) begin
      o_rd_regaddr[s*REG_ADDR_W +: REG_ADDR_W] = head.regs[s].addr;
      o_rd_regdata[s*XLEN +: XLEN]             = head.regs[s].data;
    end
`ifdef TRACER_MEMDATA_EN
    o_rd_store   = head.store;
    o_rd_memaddr = head.memaddr;
    o_rd_memdata = head.memdata;
`else
    o_rd_store   = 1'b0;
    o_rd_memaddr = '0;
    o_rd_memdata = '0;
`endif
  end

`ifndef TRACER_MEMDATA_EN
  // Memop payload inputs have no storage in this build.
  logic unused_memdata;
  assign unused_memdata = ^{i_e_memop_store, i_e_memop_addr, i_m_data};
`endif

  assign o_full         = full;
  assign o_stall        = full && !DROP_OLDEST;
  assign o_overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trace_step_buffer.sv
// Directed bench for trace_step_buffer: one overwrite-oldest and one stall/discard instance on shared stimulus.
// Latency: outputs sampled 1ns after the rising edge or at the falling edge.
// Backpressure: i_rd_ready driven per vector / sequence.
module tb_trace_step_buffer;

`ifdef TRACER_MEMDATA_EN
  localparam bit MEMDATA = 1'b1;
`else
  localparam bit MEMDATA = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nrst;
  logic         e_valid, e_memop, e_store, reg_wena, m_complete, rd_ready;
  logic [63:0]  e_pc, e_addr, reg_wdata, m_data;
  logic [31:0]  e_instr;
  logic [5:0]   reg_waddr;

  logic         a_valid, a_memop, a_store, a_full, a_stall;
  logic [63:0]  a_exec, a_pc, a_maddr, a_mdata;
  logic [31:0]  a_instr, a_ovf;
  logic [2:0]   a_regcnt;
  logic [23:0]  a_regaddr;
  logic [255:0] a_regdata;

  logic         b_valid, b_memop, b_store, b_full, b_stall;
  logic [63:0]  b_exec, b_pc, b_maddr, b_mdata;
  logic [31:0]  b_instr, b_ovf;
  logic [2:0]   b_regcnt;
  logic [23:0]  b_regaddr;
  logic [255:0] b_regdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trace_step_buffer #(.ABITS(6), .REGACT_MAX(4), .DROP_OLDEST(1'b1)) dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_e_valid(e_valid), .i_e_pc(e_pc), .i_e_instr(e_instr),
    .i_e_memop(e_memop), .i_e_memop_store(e_store), .i_e_memop_addr(e_addr),
    .i_reg_wena(reg_wena), .i_reg_waddr(reg_waddr), .i_reg_wdata(reg_wdata),
    .i_m_complete(m_complete), .i_m_data(m_data), .o_rd_valid(a_valid), .i_rd_ready(rd_ready),
    .o_rd_exec_cnt(a_exec), .o_rd_pc(a_pc), .o_rd_instr(a_instr), .o_rd_regcnt(a_regcnt),
    .o_rd_regaddr(a_regaddr), .o_rd_regdata(a_regdata), .o_rd_memop(a_memop), .o_rd_store(a_store),
    .o_rd_memaddr(a_maddr), .o_rd_memdata(a_mdata), .o_full(a_full), .o_stall(a_stall),
    .o_overflow_cnt(a_ovf)
  );

  trace_step_buffer #(.ABITS(6), .REGACT_MAX(4), .DROP_OLDEST(1'b0)) dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_e_valid(e_valid), .i_e_pc(e_pc), .i_e_instr(e_instr),
    .i_e_memop(e_memop), .i_e_memop_store(e_store), .i_e_memop_addr(e_addr),
    .i_reg_wena(reg_wena), .i_reg_waddr(reg_waddr), .i_reg_wdata(reg_wdata),
    .i_m_complete(m_complete), .i_m_data(m_data), .o_rd_valid(b_valid), .i_rd_ready(rd_ready),
    .o_rd_exec_cnt(b_exec), .o_rd_pc(b_pc), .o_rd_instr(b_instr), .o_rd_regcnt(b_regcnt),
    .o_rd_regaddr(b_regaddr), .o_rd_regdata(b_regdata), .o_rd_memop(b_memop), .o_rd_store(b_store),
    .o_rd_memaddr(b_maddr), .o_rd_memdata(b_mdata), .o_full(b_full), .o_stall(b_stall),
    .o_overflow_cnt(b_ovf)
  );

  typedef struct {
    logic        ev;
    logic [63:0] pc;
    logic        mem;
    logic        rw;
    logic [5:0]  ra;
    logic [63:0] rd;
    logic        mc;
    logic [63:0] md;
    logic        rr;
    logic        x_valid;
    logic [63:0] x_pc;
    logic [63:0] x_exec;
    logic [2:0]  x_regcnt;
    logic [5:0]  x_reg0;
    logic        x_memop;
    logic [63:0] x_md;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    e_valid = 1'b0; e_pc = '0; e_instr = '0; e_memop = 1'b0; e_store = 1'b0; e_addr = '0;
    reg_wena = 1'b0; reg_waddr = '0; reg_wdata = '0; m_complete = 1'b0; m_data = '0;
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  // One executed step (no writeback), optionally popping the head in the same cycle.
  task automatic step(input logic [63:0] pc, input logic mem, input logic pop);
    e_valid = 1'b1; e_pc = pc; e_instr = pc[31:0] + 32'd1; e_memop = mem; rd_ready = pop;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    #3;
    chk("reset a_valid", a_valid, 0);
    chk("reset b_valid", b_valid, 0);
    chk("reset a_full", a_full, 0);
    chk("reset b_stall", b_stall, 0);
    chk("reset a_ovf", a_ovf, 0);
    chk("reset a_pc", a_pc, 0);
    chk("reset a_exec", a_exec, 0);
    chk("reset a_regcnt", a_regcnt, 0);
    do_reset();

    //        ev pc        mem rw ra rd      mc md      rr  xv x_pc      xexec rc r0 xm x_md
    vt[0]  = '{1, 64'h1000, 0, 1, 5, 64'h55, 0, 64'h0,  0,  1, 64'h1000, 0,   1, 5, 0, 64'h0};
    vt[1]  = '{0, 64'h0,    0, 0, 0, 64'h0,  0, 64'h0,  1,  0, 64'h0,    0,   0, 0, 0, 64'h0};
    vt[2]  = '{1, 64'h2000, 1, 0, 0, 64'h0,  0, 64'h0,  0,  0, 64'h0,    0,   0, 0, 0, 64'h0};
    vt[3]  = '{1, 64'h2004, 0, 0, 0, 64'h0,  0, 64'h0,  0,  0, 64'h0,    0,   0, 0, 0, 64'h0};
    vt[4]  = '{0, 64'h0,    0, 0, 0, 64'h0,  0, 64'h0,  0,  0, 64'h0,    0,   0, 0, 0, 64'h0};
    vt[5]  = '{0, 64'h0,    0, 0, 0, 64'h0,  1, 64'hAB, 0,  1, 64'h2000, 1,   0, 0, 1,
               MEMDATA ? 64'hAB : 64'h0};
    vt[6]  = '{0, 64'h0,    0, 0, 0, 64'h0,  0, 64'h0,  1,  1, 64'h2004, 2,   0, 0, 0, 64'h0};
    vt[7]  = '{0, 64'h0,    0, 0, 0, 64'h0,  0, 64'h0,  1,  0, 64'h0,    0,   0, 0, 0, 64'h0};
    vt[8]  = '{1, 64'h3000, 0, 1, 1, 64'h11, 0, 64'h0,  0,  1, 64'h3000, 3,   1, 1, 0, 64'h0};
    vt[9]  = '{0, 64'h0,    0, 1, 2, 64'h22, 0, 64'h0,  0,  1, 64'h3000, 3,   2, 1, 0, 64'h0};
    vt[10] = '{0, 64'h0,    0, 1, 3, 64'h33, 0, 64'h0,  0,  1, 64'h3000, 3,   3, 1, 0, 64'h0};
    vt[11] = '{0, 64'h0,    0, 1, 4, 64'h44, 0, 64'h0,  0,  1, 64'h3000, 3,   4, 1, 0, 64'h0};
    vt[12] = '{0, 64'h0,    0, 1, 5, 64'h55, 0, 64'h0,  0,  1, 64'h3000, 3,   4, 1, 0, 64'h0};
    vt[13] = '{0, 64'h0,    0, 1, 6, 64'h66, 0, 64'h0,  0,  1, 64'h3000, 3,   4, 1, 0, 64'h0};

    for (int i = 0; i < 14; i++) begin
      e_valid = vt[i].ev; e_pc = vt[i].pc; e_instr = vt[i].pc[31:0] + 32'd1;
      e_memop = vt[i].mem; e_store = 1'b0; e_addr = vt[i].pc + 64'h100;
      reg_wena = vt[i].rw; reg_waddr = vt[i].ra; reg_wdata = vt[i].rd;
      m_complete = vt[i].mc; m_data = vt[i].md; rd_ready = vt[i].rr;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d a_valid", i), a_valid, vt[i].x_valid);
      chk($sformatf("row%0d b_valid", i), b_valid, vt[i].x_valid);
      if (vt[i].x_valid) begin
        chk($sformatf("row%0d pc", i), a_pc, vt[i].x_pc);
        chk($sformatf("row%0d instr", i), a_instr, vt[i].x_pc[31:0] + 32'd1);
        chk($sformatf("row%0d exec_cnt", i), a_exec, vt[i].x_exec);
        chk($sformatf("row%0d regcnt", i), a_regcnt, vt[i].x_regcnt);
        chk($sformatf("row%0d regaddr0", i), a_regaddr[5:0], vt[i].x_reg0);
        chk($sformatf("row%0d memop", i), a_memop, vt[i].x_memop);
        chk($sformatf("row%0d memdata", i), a_mdata, vt[i].x_md);
        chk($sformatf("row%0d store", i), a_store, 0);
      end
      @(negedge clk);
    end
    idle();

    // Six writebacks on one step: the first four are kept in slot order.
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("regaddr slot%0d", s), a_regaddr[s*6 +: 6], s + 1);
      chk($sformatf("regdata slot%0d", s), a_regdata[s*64 +: 64], 64'h11 * (s + 1));
    end

    // 65 steps with no reads: overwrite-oldest vs stall/discard.
    do_reset();
    for (int i = 0; i < 64; i++) step(64'h4000 + 64'(4 * i), 1'b0, 1'b0);
    chk("fill64 a_full", a_full, 1);
    chk("fill64 a_stall", a_stall, 0);
    chk("fill64 b_stall", b_stall, 1);
    chk("fill64 a_ovf", a_ovf, 0);
    step(64'h4100, 1'b0, 1'b0);
    chk("step65 a_ovf", a_ovf, 1);
    chk("step65 a_head_exec", a_exec, 1);
    chk("step65 a_head_pc", a_pc, 64'h4004);
    chk("step65 a_full", a_full, 1);
    chk("step65 b_ovf", b_ovf, 1);
    chk("step65 b_head_exec", b_exec, 0);
    chk("step65 b_stall", b_stall, 1);
    chk("step65 b_valid", b_valid, 1);

    // Full with a step and a pop in the same cycle loses nothing.
    do_reset();
    for (int i = 0; i < 64; i++) step(64'h4000 + 64'(4 * i), 1'b0, 1'b0);
    step(64'h4100, 1'b0, 1'b1);
    chk("exec+pop a_ovf", a_ovf, 0);
    chk("exec+pop b_ovf", b_ovf, 0);
    chk("exec+pop a_full", a_full, 1);
    chk("exec+pop b_full", b_full, 1);
    chk("exec+pop a_head_exec", a_exec, 1);
    chk("exec+pop b_head_exec", b_exec, 1);

    // Full table whose head is a pending load; the 65th step drops it in the overwrite instance.
    do_reset();
    step(64'h5000, 1'b1, 1'b0);
    for (int i = 1; i < 64; i++) step(64'h5000 + 64'(4 * i), 1'b0, 1'b0);
    chk("loadfull a_valid", a_valid, 0);
    chk("loadfull b_valid", b_valid, 0);
    step(64'h5100, 1'b0, 1'b0);
    chk("dropload a_valid", a_valid, 1);
    chk("dropload a_head_exec", a_exec, 1);
    chk("dropload a_ovf", a_ovf, 1);
    chk("dropload b_valid", b_valid, 0);
    chk("dropload b_head_exec", b_exec, 0);
    m_complete = 1'b1; m_data = 64'hCD;
    @(posedge clk);
    #1;
    idle();
    chk("stale complete a_head_exec", a_exec, 1);
    chk("stale complete a_memdata", a_mdata, 0);
    chk("stale complete a_valid", a_valid, 1);
    chk("complete b_valid", b_valid, 1);
    chk("complete b_head_exec", b_exec, 0);
    chk("complete b_memdata", b_mdata, MEMDATA ? 64'hCD : 64'h0);
    @(negedge clk);

    // Asynchronous reset mid-stream clears readout before the next edge.
    #2;
    nrst = 1'b0;
    #1;
    chk("async rst a_valid", a_valid, 0);
    chk("async rst b_valid", b_valid, 0);
    chk("async rst a_full", a_full, 0);
    chk("async rst a_ovf", a_ovf, 0);
    chk("async rst a_pc", a_pc, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("post rst idle a_valid", a_valid, 0);
    step(64'h6000, 1'b0, 1'b0);
    chk("post rst a_valid", a_valid, 1);
    chk("post rst a_exec", a_exec, 0);
    chk("post rst a_pc", a_pc, 64'h6000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
